// File: rtl/pads_in_cond_pkg.sv
// Shared defaults and helpers for the input pad conditioner.
// Imported by the per-channel slice and the multi-channel top.
package pads_in_pkg;

    localparam int NUM_CH_DEF      = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF   = 16;

    // Counter wide enough to hold 0..n without wrapping.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pads_in_cond_ch.sv
// One conditioned input channel: synchroniser, optional debouncer
// and registered rise/fall edge pulses.
module pads_in_cond_ch
    import pads_in_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter bit DB_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = cnt_w(DB_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, fall_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Counter only advances while the synchronised level disagrees.
    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        if (!DB_EN) begin
            dout_d = s;
        end else if (s != dout_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                dout_d = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            dout_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= dout_d & ~dout_q;
            fall_q <= ~dout_d & dout_q;
        end
    end

    assign dout_o = dout_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/pads_in_cond.sv
// Multi-channel input pad conditioner; one independent slice per
// channel, debounce selectable per bit of DB_EN.
module pads_in_cond
    import pads_in_pkg::*;
#(
    parameter int                NUM_CH      = NUM_CH_DEF,
    parameter int                SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int                DB_CYCLES   = DB_CYCLES_DEF,
    parameter logic [NUM_CH-1:0] DB_EN       = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] din,
    output logic [NUM_CH-1:0] dout,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pads_in_cond_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .DB_EN       (DB_EN[i])
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .din_i  (din[i]),
            .dout_o (dout[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

endmodule
